// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit fused with a word-organised synchronous data memory.
// Latency: response pulse two cycles after acceptance, or three for a split misaligned access.
// Backpressure: req_ready_o is high only in IDLE; the response pulse cannot be stalled.
// Optional macro LSU_MISALIGN_SPLIT_EN splits word-crossing accesses over two memory words.

`ifndef LSU_OPCODE_NONE
`define LSU_OPCODE_NONE 8'h00
`define LSU_OPCODE_LB   8'h01
`define LSU_OPCODE_LH   8'h02
`define LSU_OPCODE_LW   8'h03
`define LSU_OPCODE_LBU  8'h04
`define LSU_OPCODE_LHU  8'h05
`define LSU_OPCODE_SB   8'h06
`define LSU_OPCODE_SH   8'h07
`define LSU_OPCODE_SW   8'h08
`endif

module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [7:0]        lsu_opcode_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SECOND, S_RESP} state_t;
  state_t state, state_nxt;

  logic [7:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd0_q;
  logic [31:0]       mem [DEPTH];

  logic              is_load, is_store, known, sgn;
  logic [2:0]        size;
  logic [1:0]        off;
  logic [ADDR_W:0]   last_byte;
  logic              oor, misalign, split, err, do_split;
  logic [3:0]        mask4;
  logic [7:0]        lane_mask;
  logic [63:0]       wide_wdata;
  logic [IW-1:0]     word_idx, rd_idx;
  logic [31:0]       rd_word, shifted, fmt;
  logic [63:0]       merged;

  // Decode the captured opcode into access class, width and extension kind
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    known    = 1'b1;
    sgn      = 1'b0;
    size     = 3'd0;
    case (op_q)
      `LSU_OPCODE_NONE: ;
      `LSU_OPCODE_LB:  begin is_load = 1'b1;  size = 3'd1; sgn = 1'b1; end
      `LSU_OPCODE_LH:  begin is_load = 1'b1;  size = 3'd2; sgn = 1'b1; end
      `LSU_OPCODE_LW:  begin is_load = 1'b1;  size = 3'd4; end
      `LSU_OPCODE_LBU: begin is_load = 1'b1;  size = 3'd1; end
      `LSU_OPCODE_LHU: begin is_load = 1'b1;  size = 3'd2; end
      `LSU_OPCODE_SB:  begin is_store = 1'b1; size = 3'd1; end
      `LSU_OPCODE_SH:  begin is_store = 1'b1; size = 3'd2; end
      `LSU_OPCODE_SW:  begin is_store = 1'b1; size = 3'd4; end
      default:         known = 1'b0;
    endcase
  end

  // Address checks, lane masks and store-data placement across a two-word window
  always_comb begin
    off        = addr_q[1:0];
    // Extra top bit keeps the last-byte sum from wrapping back into range
    last_byte  = {1'b0, addr_q} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
    oor        = (size != 3'd0) && (last_byte >= LIMIT);
`ifdef LSU_MISALIGN_SPLIT_EN
    split      = (size != 3'd0) && (({1'b0, off} + size) > 3'd4);
    misalign   = 1'b0;
`else
    split      = 1'b0;
    misalign   = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'd0));
`endif
    err        = !known || oor || misalign;
    do_split   = split && !err;
    case (size)
      3'd1:    mask4 = 4'b0001;
      3'd2:    mask4 = 4'b0011;
      3'd4:    mask4 = 4'b1111;
      default: mask4 = 4'b0000;
    endcase
    lane_mask  = {4'b0000, mask4} << off;
    wide_wdata = {32'd0, wdata_q} << {off, 3'b000};
    word_idx   = addr_q[IW+1:2];
  end

  // Read path: word N in ACCESS, word N+1 in SECOND, merged then extended
  always_comb begin
    rd_idx  = (state == S_SECOND) ? word_idx + IW'(1) : word_idx;
    rd_word = mem[rd_idx];
    merged  = (state == S_SECOND) ? {rd_word, rd0_q} : {32'd0, rd_word};
    shifted = 32'(merged >> {off, 3'b000});
    fmt     = 32'd0;
    if (is_load && !err) begin
      case (size)
        3'd1:    fmt = sgn ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
        3'd2:    fmt = sgn ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
        default: fmt = shifted;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: IDLE -> ACCESS -> (SECOND) -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid_i) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = do_split ? S_SECOND : S_RESP;
      S_SECOND: state_nxt = S_RESP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    req_ready_o = (state == S_IDLE);
    rsp_valid_o = (state == S_RESP);
    busy_o      = (state != S_IDLE);
  end

  // Request capture, first-word hold and response data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= `LSU_OPCODE_NONE;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rd0_q   <= 32'd0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid_i) begin
        op_q    <= lsu_opcode_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state == S_ACCESS) rd0_q <= rd_word;
      if ((state == S_ACCESS && !do_split) || state == S_SECOND) begin
        rdata_o <= fmt;
        err_o   <= err;
      end
    end
  end

  // Byte-lane writes: low lanes to word N in ACCESS, high lanes to word N+1 in SECOND
  always_ff @(posedge clk) begin
    if (is_store && !err) begin
      if (state == S_ACCESS) begin
        for (int i = 0; i < 4; i++)
          if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wide_wdata[8*i +: 8];
      end else if (state == S_SECOND) begin
        for (int i = 0; i < 4; i++)
          if (lane_mask[4+i]) mem[rd_idx][8*i +: 8] <= wide_wdata[32+8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: reset, aligned/extended loads, byte stores,
// misaligned handling (both builds of LSU_MISALIGN_SPLIT_EN), range and mid-op reset.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  localparam logic [7:0] OP_NONE = 8'h00, OP_LB = 8'h01, OP_LH = 8'h02, OP_LW = 8'h03,
                         OP_LBU = 8'h04, OP_LHU = 8'h05, OP_SB = 8'h06, OP_SH = 8'h07,
                         OP_SW = 8'h08;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  lsu_opcode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  lsu_mem_ctrl #(.ADDR_W(32), .DEPTH(1024)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .lsu_opcode_i(lsu_opcode), .addr_i(addr), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rdata_o(rdata), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Drive one request and wait (bounded) for its response; lat counts negedges after acceptance
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat, output logic rdy_low);
    @(negedge clk);
    req_valid = 1'b1; lsu_opcode = op; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1; rdy_low = 1'b1; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) rdy_low = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = i; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0", rsp_valid); end
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_aligned;
    logic [31:0] rd; logic e, rl; int lat;
    issue(OP_SW, 32'h0, 32'hABCDEF89, rd, e, lat, rl);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw0_lat got=%0d exp=2", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sw0_err got=%b exp=0", e); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL sw0_ready_low got=%b exp=1", rl); end
    issue(OP_LW, 32'h0, 32'h0, rd, e, lat, rl);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw0_lat got=%0d exp=2", lat); end
    checks++; if (rd !== 32'hABCDEF89) begin failures++; $display("FAIL lw0_data got=%h exp=abcdef89", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL lw0_err got=%b exp=0", e); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL lw0_ready_low got=%b exp=1", rl); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_one_cycle got=%b exp=0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_rsp got=%b exp=1", req_ready); end
  endtask

  task automatic test_extension;
    logic [31:0] rd; logic e, rl; int lat;
    issue(OP_SW, 32'h4, 32'hA1C2E394, rd, e, lat, rl);
    issue(OP_LB, 32'h7, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hFFFFFFA1) begin failures++; $display("FAIL lb7 got=%h exp=ffffffa1", rd); end
    issue(OP_LBU, 32'h7, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h000000A1) begin failures++; $display("FAIL lbu7 got=%h exp=000000a1", rd); end
    issue(OP_LH, 32'h6, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hFFFFA1C2) begin failures++; $display("FAIL lh6 got=%h exp=ffffa1c2", rd); end
    issue(OP_LHU, 32'h4, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h0000E394) begin failures++; $display("FAIL lhu4 got=%h exp=0000e394", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL lhu4_err got=%b exp=0", e); end
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; logic e, rl; int lat;
    issue(OP_SB, 32'h5, 32'h08439341, rd, e, lat, rl);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sb5_err got=%b exp=0", e); end
    issue(OP_LW, 32'h4, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hA1C24194) begin failures++; $display("FAIL sb5_word got=%h exp=a1c24194", rd); end
    issue(OP_SH, 32'h2, 32'h0000BEEF, rd, e, lat, rl);
    issue(OP_LW, 32'h0, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hBEEFEF89) begin failures++; $display("FAIL sh2_word got=%h exp=beefef89", rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic e, rl; int lat;
    issue(OP_SW, 32'h8, 32'hABCDEF89, rd, e, lat, rl);
    issue(OP_SW, 32'h7, 32'h08439341, rd, e, lat, rl);
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sw7_err got=%b exp=0", e); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL sw7_lat got=%0d exp=3", lat); end
    issue(OP_LW, 32'h4, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h41C24194) begin failures++; $display("FAIL sw7_word4 got=%h exp=41c24194", rd); end
    issue(OP_LW, 32'h8, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hAB084393) begin failures++; $display("FAIL sw7_word8 got=%h exp=ab084393", rd); end
    issue(OP_LW, 32'h7, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h08439341) begin failures++; $display("FAIL lw7_data got=%h exp=08439341", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL lw7_lat got=%0d exp=3", lat); end
    issue(OP_LH, 32'h5, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hFFFFC241) begin failures++; $display("FAIL lh5 got=%h exp=ffffc241", rd); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL lh5_err got=%b exp=0", e); end
`else
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL sw7_err got=%b exp=1", e); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw7_lat got=%0d exp=2", lat); end
    issue(OP_LW, 32'h4, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hA1C24194) begin failures++; $display("FAIL sw7_word4 got=%h exp=a1c24194", rd); end
    issue(OP_LW, 32'h8, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hABCDEF89) begin failures++; $display("FAIL sw7_word8 got=%h exp=abcdef89", rd); end
    issue(OP_LW, 32'h7, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL lw7_err got=%b exp=1", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL lw7_data got=%h exp=0", rd); end
    issue(OP_LH, 32'h5, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL lh5 got=%h exp=0", rd); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL lh5_err got=%b exp=1", e); end
`endif
  endtask

  task automatic test_range;
    logic [31:0] rd; logic e, rl; int lat;
    issue(OP_LW, 32'h1000, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL oor_data got=%h exp=0", rd); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL oor_lat got=%0d exp=2", lat); end
    issue(OP_SW, 32'h0FFC, 32'h12345678, rd, e, lat, rl);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sw_top_err got=%b exp=0", e); end
    issue(OP_LW, 32'h0FFC, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL lw_top got=%h exp=12345678", rd); end
    issue(OP_LB, 32'h0FFF, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'h00000012) begin failures++; $display("FAIL lb_top got=%h exp=00000012", rd); end
    issue(OP_LH, 32'h0FFF, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL lh_top_err got=%b exp=1", e); end
    issue(OP_LW, 32'hFFFFFFFC, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL nowrap_err got=%b exp=1", e); end
    issue(OP_NONE, 32'h0FFC, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL none_err got=%b exp=0", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL none_data got=%h exp=0", rd); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL none_lat got=%0d exp=2", lat); end
    issue(8'h5A, 32'h0, 32'h0, rd, e, lat, rl);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL badop_err got=%b exp=1", e); end
    checks++; if (rd !== 32'd0) begin failures++; $display("FAIL badop_data got=%h exp=0", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic e, rl, seen; int lat;
    @(negedge clk);
    req_valid = 1'b1; lsu_opcode = OP_SW; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_rsp got=%b exp=0", seen); end
    issue(OP_LW, 32'h0, 32'h0, rd, e, lat, rl);
    checks++; if (rd !== 32'hBEEFEF89) begin failures++; $display("FAIL post_rst_lw got=%h exp=beefef89", rd); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL post_rst_lat got=%0d exp=2", lat); end
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; lsu_opcode = 8'h00; addr = 32'd0; wdata = 32'd0;
    test_reset;
    test_aligned;
    test_extension;
    test_byte_store;
    test_misaligned;
    test_range;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
